vec_load_unit: RTL
==================

Name: vec_load_unit

Overview:
- Vector load stage directly upstream of the 128-bit vector register file write port.
- On a load request, fetches four consecutive 32-bit beats from data memory and assembles them into one 128-bit vector.
- Writes the vector to the destination register through a single-cycle we3/ra3/wd3 write.
- All outputs are registered on posedge clk, so they are stable when the register file samples on negedge clk.

Parameters:
- MEM_AW, 16, memory word-address width.
- BEAT_W, 32, memory data width per beat.
- VEC_W, 128, vector width; beat count BEATS = VEC_W/BEAT_W (4), derived, not overridable.
- TIMEOUT, 255, ack watchdog limit in cycles; used only with VLOAD_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  load request, sampled only in IDLE.
- base_addr  in  MEM_AW  word address of beat 0.
- dest_reg  in  4  destination vector register; valid range 0..14.
- busy  out  1  high while not in IDLE.
- mem_req  out  1  memory read request.
- mem_addr  out  MEM_AW  read word address.
- mem_ack  in  1  memory accepts the request; mem_rdata is valid in the same cycle.
- mem_rdata  in  BEAT_W  read data.
- we3  out  1  register file write enable.
- ra3  out  4  register file write address.
- wd3  out  VEC_W  register file write data.
- done  out  1  one-cycle pulse on successful write.
- err  out  1  one-cycle pulse on rejected or aborted load.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; beat counter 0; busy, mem_req, we3, done and err all 0; mem_addr=0; ra3=0; wd3=0. Partially assembled data is discarded.
- States: IDLE, FETCH, WRITE.
- IDLE:
  - start=1 with dest_reg<=14: latch base_addr and dest_reg; go to FETCH with mem_req=1 and mem_addr=base_addr next cycle.
  - start=1 with dest_reg=15: no fetch, no write; err=1 for one cycle; stay in IDLE.
- FETCH:
  - mem_req stays high until the last beat is acked.
  - On each posedge with mem_req=1 and mem_ack=1, capture mem_rdata into lane k, i.e. wd3[k*BEAT_W +: BEAT_W], with beat 0 in the LSBs; then k++ and mem_addr++.
  - mem_addr wraps modulo 2^MEM_AW.
  - After beat BEATS-1 is acked: mem_req=0; go to WRITE.
  - mem_ack=0 holds mem_addr and k unchanged.
- WRITE:
  - Exactly one cycle with we3=1, ra3=dest, wd3=assembled vector, done=1.
  - Next state IDLE; we3=0 and done=0 the following cycle.
- Hold values: ra3 and wd3 keep their last values after a write until the next write; lanes are overwritten in place during the next FETCH.
- Latency: start accepted in cycle 0; with mem_ack held high, mem_req is high in cycles 1-4 and we3/done are high in cycle 5. busy is high in cycles 1-5.
- start while busy is ignored; there is no queueing.
- mem_ack while mem_req=0 is ignored.
- Reset asserted mid-FETCH or mid-WRITE aborts immediately. No write occurs if reset is low at the WRITE cycle edge.

Optional Feature:
- Macro: VLOAD_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on entry to FETCH and on every acked beat, and increments on each FETCH cycle with mem_ack=0.
  - When the count reaches TIMEOUT: mem_req=0, err=1 for one cycle, no we3, return to IDLE.
- Not defined: FETCH waits indefinitely for mem_ack; err is driven only by the dest_reg=15 rejection.

Test Plan:
- Basic load: base_addr=0x0010, dest_reg=3, mem_ack held high, rdata 0x11111111, 0x22222222, 0x33333333, 0x44444444 -> mem_addr 0x10..0x13 in cycles 1-4; cycle 5: we3=1, ra3=3, wd3=0x44444444_33333333_22222222_11111111, done=1.
- Stalled memory: mem_ack low 2 cycles before beat 1 -> mem_addr holds 0x0011 during the stall; we3 in cycle 7; data unchanged from the basic load.
- Address wrap: base_addr=0xFFFE -> mem_addr sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001; correct write to dest.
- Illegal destination: start with dest_reg=15 -> err pulse the next cycle, mem_req and we3 never assert, busy stays 0; start pulsed while busy -> ignored, exactly one write.
- Reset mid-operation: rst=0 after beat 2 -> all outputs 0 immediately, no we3. New load after release -> wd3 contains only the new beats.
- With VLOAD_TIMEOUT_EN and TIMEOUT=8: mem_ack never asserts -> err pulses after 8 stalled cycles, mem_req drops, we3 stays 0, busy returns to 0.

Source files
------------

// File: rtl/vec_load_unit.sv
// Vector load stage: fetches BEATS memory words and writes them as one vector to the register file.
// Optional ack watchdog enabled by defining VLOAD_TIMEOUT_EN.
module vec_load_unit #(
  parameter int MEM_AW  = 16,
  parameter int BEAT_W  = 32,
  parameter int VEC_W   = 128,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [MEM_AW-1:0] base_addr,
  input  logic [3:0]        dest_reg,
  output logic              busy,
  output logic              mem_req,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [BEAT_W-1:0] mem_rdata,
  output logic              we3,
  output logic [3:0]        ra3,
  output logic [VEC_W-1:0]  wd3,
  output logic              done,
  output logic              err
);

  localparam int BEATS   = VEC_W / BEAT_W;
  localparam int BEAT_CW = (BEATS > 1) ? $clog2(BEATS) : 1;

  if ((VEC_W % BEAT_W) != 0 || BEATS < 1 || TIMEOUT < 1) begin : g_bad_cfg
    $error("vec_load_unit: VEC_W must be a multiple of BEAT_W and TIMEOUT must be positive");
  end

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WRITE} state_t;

  state_t              state_q, state_d;
  logic [BEAT_CW-1:0]  beat_q, beat_d;
  logic [3:0]          dest_q, dest_d;
  logic                busy_q, busy_d;
  logic                mem_req_q, mem_req_d;
  logic [MEM_AW-1:0]   mem_addr_q, mem_addr_d;
  logic                we3_q, we3_d;
  logic [3:0]          ra3_q, ra3_d;
  logic [VEC_W-1:0]    wd3_q, wd3_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic accept, reject, beat_ack, last_ack, timeout_hit;

  assign accept   = (state_q == S_IDLE) && start && (dest_reg != 4'hF);
  assign reject   = (state_q == S_IDLE) && start && (dest_reg == 4'hF);
  // mem_req_q is only ever high in FETCH, so a stray ack elsewhere is ignored.
  assign beat_ack = (state_q == S_FETCH) && mem_req_q && mem_ack;
  assign last_ack = beat_ack && (beat_q == BEAT_CW'(BEATS - 1));

`ifdef VLOAD_TIMEOUT_EN
  localparam int WDOG_W = $clog2(TIMEOUT + 1);
  logic [WDOG_W-1:0] wdog_q, wdog_d;

  // Firing on TIMEOUT-1 means the count reaches TIMEOUT on the aborting edge.
  assign timeout_hit = (state_q == S_FETCH) && !mem_ack && (wdog_q == WDOG_W'(TIMEOUT - 1));

  always_comb begin
    wdog_d = wdog_q;
    if (accept || beat_ack) begin
      wdog_d = '0;
    end else if (state_q == S_FETCH) begin
      wdog_d = wdog_q + WDOG_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      beat_q     <= '0;
      dest_q     <= '0;
      busy_q     <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      we3_q      <= 1'b0;
      ra3_q      <= '0;
      wd3_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      dest_q     <= dest_d;
      busy_q     <= busy_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      we3_q      <= we3_d;
      ra3_q      <= ra3_d;
      wd3_q      <= wd3_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_FETCH;
      S_FETCH: begin
        if (last_ack) begin
          state_d = S_WRITE;
        end else if (timeout_hit) begin
          state_d = S_IDLE;
        end
      end
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are computed one cycle ahead so every port comes straight from a flop.
  always_comb begin
    busy_d     = (state_d != S_IDLE);
    beat_d     = beat_q;
    dest_d     = dest_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    we3_d      = 1'b0;
    ra3_d      = ra3_q;
    wd3_d      = wd3_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    if (accept) begin
      mem_req_d  = 1'b1;
      mem_addr_d = base_addr;
      dest_d     = dest_reg;
      beat_d     = '0;
    end
    if (reject) begin
      err_d = 1'b1;
    end
    if (beat_ack) begin
      wd3_d[int'(beat_q)*BEAT_W +: BEAT_W] = mem_rdata;
      beat_d     = beat_q + BEAT_CW'(1);
      mem_addr_d = mem_addr_q + MEM_AW'(1);
    end
    if (last_ack) begin
      mem_req_d = 1'b0;
      we3_d     = 1'b1;
      done_d    = 1'b1;
      ra3_d     = dest_q;
    end
    if (timeout_hit) begin
      mem_req_d = 1'b0;
      err_d     = 1'b1;
    end
  end

  assign busy     = busy_q;
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign we3      = we3_q;
  assign ra3      = ra3_q;
  assign wd3      = wd3_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule
